hdmi_sync_normalizer: RTL and testbench
=======================================

HDMI_SYNC_NORMALIZER -- requirements
Module: hdmi_sync_normalizer

Interface
REQ-001 HCNT_W, default 12, width of horizontal pixel counters.
REQ-002 VCNT_W, default 11, width of vertical line counters.
REQ-003 clk_sys  in  1  single clock for all logic.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 ce_pix  in  1  pixel enable; all video sampling and counting occur only on clk_sys edges with ce_pix=1.
REQ-006 rgb_in  in  24  pixel {R,G,B}, 8 bits each.
REQ-007 HSync, VSync, HBlank, VBlank  in  1 each  syncs of either polarity; blanks active-high.
REQ-008 rgb_out  out  24  registered pixel, forced to 0 when de_out=0.
REQ-009 hs_out, vs_out  out  1 each  syncs normalised to active-high.
REQ-010 de_out  out  1  ~(HBlank|VBlank), registered.
REQ-011 hs_pol, vs_pol  out  1 each  1 = input sync detected active-low.
REQ-012 h_total, h_active  out  HCNT_W  pixels per line; non-blanked pixels per line.
REQ-013 v_total, v_active  out  VCNT_W  lines per frame; non-blanked lines per frame.
REQ-014 meas_valid  out  1  timing stable over two consecutive frames.

Function
REQ-015 Video path latency is exactly one ce_pix: rgb_out, de_out, hs_out=HSync^hs_pol, vs_out=VSync^vs_pol; outputs hold between ce_pix pulses.
REQ-016 Line end is the HBlank rising edge (sampled on ce_pix); frame end is the VBlank rising edge.
REQ-017 Per line: count all pixels (hcnt), pixels with HBlank=0 (hact), pixels with HSync=1 (hhi); cleared at line end after capture, restarting at 1 for the edge pixel.
REQ-018 Per frame: count line ends (vcnt), line ends with VBlank=0 (vact), line ends with VSync=1 (vhi); cleared at frame end after capture.
REQ-019 At line end: hs_pol_next = (hhi > hcnt>>1); at frame end: vs_pol_next = (vhi > vcnt>>1); hs_pol/vs_pol update only at frame end and take effect on the next ce_pix.
REQ-020 All counters saturate at all-ones; no wrap-around.
REQ-021 Simultaneous line end and frame end: the line is captured first, so the frame counts include that line.
REQ-022 FSM states SEARCH, FIRST, LOCKED; SEARCH->FIRST on first frame end (no capture); FIRST->LOCKED at frame end when captured h_total/v_total equal the previous frame's, else stay FIRST.
REQ-023 LOCKED->FIRST at any frame end whose h_total or v_total differs from the stored values; meas_valid=1 only in LOCKED.
REQ-024 h_total/h_active/v_total/v_active outputs update at every frame end from FIRST or LOCKED (last line's values for h_*).

Reset
REQ-025 reset_n=0 asynchronously clears all outputs, counters, polarities and stored measurements to 0 and forces FSM to SEARCH; assertion mid-frame discards the partial frame.
REQ-026 Reset release requires a full frame end before any measurement or polarity update.

Configuration
REQ-027 HDMI_SYNC_MEAS_EN defined: h_total, h_active, v_total, v_active, meas_valid and FSM implemented per REQ-017..REQ-024.
REQ-028 HDMI_SYNC_MEAS_EN undefined: those outputs tie to 0, active/total counters and FSM removed; polarity detection and video path unchanged.

Structure
REQ-029 Package hdmi_sync_pkg holds the FSM state enum and default HCNT_W/VCNT_W constants.
REQ-030 One sub-module, sync_pol_detect (generic counter width), instantiated twice for horizontal and vertical polarity/high-count logic.

Verification
REQ-031 800x525 frame, 640x480 active, HSync low 96 px, VSync low 2 lines, ce_pix every 4th clk -> after 1st counted frame end hs_pol=vs_pol=1, hs_out high 96 px, vs_out high 2 lines.
REQ-032 Same timing, three frames -> h_total=800, h_active=640, v_total=525, v_active=480, meas_valid rises at 2nd counted frame end.
REQ-033 Switch to h_total=858 mid-stream -> meas_valid drops at next frame end, returns one frame later with h_total=858.
REQ-034 reset_n pulsed mid-frame -> all outputs 0 immediately, meas_valid returns only after two counted frame ends.
REQ-035 HSync held high 5000 px with no HBlank edge -> hcnt saturates at 4095, no wrap; h_total=4095 reported.
REQ-036 Build without HDMI_SYNC_MEAS_EN, run REQ-031 stimulus -> polarity and video identical, measurement outputs constant 0.

Source files
------------

// File: rtl/hdmi_sync_pkg.sv
// Shared types and default counter widths for the HDMI sync normalizer.
package hdmi_sync_pkg;

  localparam int unsigned HCNT_W_DEF = 12;
  localparam int unsigned VCNT_W_DEF = 11;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_FIRST  = 2'd1,
    ST_LOCKED = 2'd2
  } meas_state_e;

endpackage

// File: rtl/sync_pol_detect.sv
// Per-period sample/high counters with a majority-vote polarity decision at period close.
// CLOSE_INCL=1: a sample coinciding with close belongs to the closing period; else it opens the new one.
module sync_pol_detect #(
  parameter int unsigned CNT_W      = 12,
  parameter bit          CLOSE_INCL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             sync_in,
  input  logic             close,
  output logic [CNT_W-1:0] total_c,
  output logic             pol_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] hi_close;
  logic             hi_inc;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic b);
    return (b && (a != '1)) ? a + CNT_W'(1) : a;
  endfunction

  assign hi_inc = inc & sync_in;

  always_comb begin
    total_c  = CLOSE_INCL ? sat_add(cnt_q, inc) : cnt_q;
    hi_close = CLOSE_INCL ? sat_add(hi_q, hi_inc) : hi_q;
    pol_c    = hi_close > (total_c >> 1);
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    if (close) begin
      cnt_d = CLOSE_INCL ? '0 : CNT_W'(inc);
      hi_d  = CLOSE_INCL ? '0 : CNT_W'(hi_inc);
    end else begin
      cnt_d = sat_add(cnt_q, inc);
      hi_d  = sat_add(hi_q, hi_inc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      hi_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
    end
  end

endmodule

// File: rtl/hdmi_sync_normalizer.sv
// Normalises HDMI syncs to active-high, registers the video path and (with HDMI_SYNC_MEAS_EN
// defined) measures line/frame timing and reports when it is stable.
module hdmi_sync_normalizer
  import hdmi_sync_pkg::*;
#(
  parameter int unsigned HCNT_W = HCNT_W_DEF,
  parameter int unsigned VCNT_W = VCNT_W_DEF
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ce_pix,
  input  logic [23:0]       rgb_in,
  input  logic              HSync,
  input  logic              VSync,
  input  logic              HBlank,
  input  logic              VBlank,
  output logic [23:0]       rgb_out,
  output logic              hs_out,
  output logic              vs_out,
  output logic              de_out,
  output logic              hs_pol,
  output logic              vs_pol,
  output logic [HCNT_W-1:0] h_total,
  output logic [HCNT_W-1:0] h_active,
  output logic [VCNT_W-1:0] v_total,
  output logic [VCNT_W-1:0] v_active,
  output logic              meas_valid
);

  logic              hblank_prev_q, hblank_prev_d;
  logic              vblank_prev_q, vblank_prev_d;
  logic [23:0]       rgb_q, rgb_d;
  logic              de_q, de_d;
  logic              hs_out_q, hs_out_d;
  logic              vs_out_q, vs_out_d;
  logic              hs_pol_q, hs_pol_d;
  logic              vs_pol_q, vs_pol_d;
  logic              hs_pol_next_q, hs_pol_next_d;
  logic              armed_q, armed_d;
  logic              line_end_c, frame_end_c;
  logic [HCNT_W-1:0] h_tot_c;
  logic [VCNT_W-1:0] v_tot_c;
  logic              h_pol_c, v_pol_c;

  assign line_end_c  = ce_pix & HBlank & ~hblank_prev_q;
  assign frame_end_c = ce_pix & VBlank & ~vblank_prev_q;

  sync_pol_detect #(.CNT_W(HCNT_W), .CLOSE_INCL(1'b0)) u_h_det (
    .clk     (clk_sys),
    .rst_n   (reset_n),
    .inc     (ce_pix),
    .sync_in (HSync),
    .close   (line_end_c),
    .total_c (h_tot_c),
    .pol_c   (h_pol_c)
  );

  sync_pol_detect #(.CNT_W(VCNT_W), .CLOSE_INCL(1'b1)) u_v_det (
    .clk     (clk_sys),
    .rst_n   (reset_n),
    .inc     (line_end_c),
    .sync_in (VSync),
    .close   (frame_end_c),
    .total_c (v_tot_c),
    .pol_c   (v_pol_c)
  );

  // Video path and polarity tracking; polarity only moves after one full frame since reset.
  always_comb begin
    hblank_prev_d = hblank_prev_q;
    vblank_prev_d = vblank_prev_q;
    rgb_d         = rgb_q;
    de_d          = de_q;
    hs_out_d      = hs_out_q;
    vs_out_d      = vs_out_q;
    hs_pol_d      = hs_pol_q;
    vs_pol_d      = vs_pol_q;
    hs_pol_next_d = hs_pol_next_q;
    armed_d       = armed_q;
    if (ce_pix) begin
      hblank_prev_d = HBlank;
      vblank_prev_d = VBlank;
      de_d          = ~(HBlank | VBlank);
      rgb_d         = (HBlank | VBlank) ? 24'h0 : rgb_in;
      hs_out_d      = HSync ^ hs_pol_q;
      vs_out_d      = VSync ^ vs_pol_q;
    end
    if (line_end_c) begin
      hs_pol_next_d = h_pol_c;
    end
    if (frame_end_c) begin
      armed_d = 1'b1;
      if (armed_q) begin
        hs_pol_d = line_end_c ? h_pol_c : hs_pol_next_q;
        vs_pol_d = v_pol_c;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hblank_prev_q <= 1'b0;
      vblank_prev_q <= 1'b0;
      rgb_q         <= '0;
      de_q          <= 1'b0;
      hs_out_q      <= 1'b0;
      vs_out_q      <= 1'b0;
      hs_pol_q      <= 1'b0;
      vs_pol_q      <= 1'b0;
      hs_pol_next_q <= 1'b0;
      armed_q       <= 1'b0;
    end else begin
      hblank_prev_q <= hblank_prev_d;
      vblank_prev_q <= vblank_prev_d;
      rgb_q         <= rgb_d;
      de_q          <= de_d;
      hs_out_q      <= hs_out_d;
      vs_out_q      <= vs_out_d;
      hs_pol_q      <= hs_pol_d;
      vs_pol_q      <= vs_pol_d;
      hs_pol_next_q <= hs_pol_next_d;
      armed_q       <= armed_d;
    end
  end

  assign rgb_out = rgb_q;
  assign de_out  = de_q;
  assign hs_out  = hs_out_q;
  assign vs_out  = vs_out_q;
  assign hs_pol  = hs_pol_q;
  assign vs_pol  = vs_pol_q;

`ifdef HDMI_SYNC_MEAS_EN
  meas_state_e       state_q, state_d;
  logic [HCNT_W-1:0] hact_q, hact_d;
  logic [HCNT_W-1:0] line_tot_q, line_tot_d;
  logic [HCNT_W-1:0] line_act_q, line_act_d;
  logic [HCNT_W-1:0] h_total_q, h_total_d;
  logic [HCNT_W-1:0] h_active_q, h_active_d;
  logic [VCNT_W-1:0] vact_q, vact_d;
  logic [VCNT_W-1:0] vact_close_c;
  logic [VCNT_W-1:0] v_total_q, v_total_d;
  logic [VCNT_W-1:0] v_active_q, v_active_d;
  logic              meas_valid_q, meas_valid_d;
  logic              vact_inc_c;

  // Active-pixel/line counters, per-frame capture and lock FSM; a line end on the frame-end
  // sample is folded into that frame's capture.
  always_comb begin
    state_d      = state_q;
    hact_d       = hact_q;
    line_tot_d   = line_tot_q;
    line_act_d   = line_act_q;
    h_total_d    = h_total_q;
    h_active_d   = h_active_q;
    v_total_d    = v_total_q;
    v_active_d   = v_active_q;
    vact_inc_c   = line_end_c & ~VBlank;
    vact_close_c = (vact_inc_c && (vact_q != '1)) ? vact_q + VCNT_W'(1) : vact_q;
    vact_d       = frame_end_c ? '0 : vact_close_c;
    if (line_end_c) begin
      hact_d     = '0;
      line_tot_d = h_tot_c;
      line_act_d = hact_q;
    end else if (ce_pix && !HBlank && (hact_q != '1)) begin
      hact_d = hact_q + HCNT_W'(1);
    end
    if (frame_end_c) begin
      if (state_q == ST_SEARCH) begin
        state_d = ST_FIRST;
      end else begin
        h_total_d  = line_end_c ? h_tot_c : line_tot_q;
        h_active_d = line_end_c ? hact_q : line_act_q;
        v_total_d  = v_tot_c;
        v_active_d = vact_close_c;
        state_d    = ((h_total_d == h_total_q) && (v_total_d == v_total_q)) ? ST_LOCKED : ST_FIRST;
      end
    end
    meas_valid_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_SEARCH;
      hact_q       <= '0;
      line_tot_q   <= '0;
      line_act_q   <= '0;
      h_total_q    <= '0;
      h_active_q   <= '0;
      vact_q       <= '0;
      v_total_q    <= '0;
      v_active_q   <= '0;
      meas_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hact_q       <= hact_d;
      line_tot_q   <= line_tot_d;
      line_act_q   <= line_act_d;
      h_total_q    <= h_total_d;
      h_active_q   <= h_active_d;
      vact_q       <= vact_d;
      v_total_q    <= v_total_d;
      v_active_q   <= v_active_d;
      meas_valid_q <= meas_valid_d;
    end
  end

  assign h_total    = h_total_q;
  assign h_active   = h_active_q;
  assign v_total    = v_total_q;
  assign v_active   = v_active_q;
  assign meas_valid = meas_valid_q;
`else
  logic unused_meas_c;
  assign unused_meas_c = ^{h_tot_c, v_tot_c};

  assign h_total    = '0;
  assign h_active   = '0;
  assign v_total    = '0;
  assign v_active   = '0;
  assign meas_valid = 1'b0;
`endif

endmodule

// File: tb/tb_hdmi_sync_normalizer.sv
// Randomised-timing bench for hdmi_sync_normalizer; expectations derive from the generated
// frame geometry (sync polarity, totals, active sizes) rather than from counter behaviour.
module tb_hdmi_sync_normalizer;

  localparam int unsigned HW = 12;
  localparam int unsigned VW = 11;

  logic          clk_sys;
  logic          reset_n;
  logic          ce_pix;
  logic [23:0]   rgb_in;
  logic          HSync, VSync, HBlank, VBlank;
  logic [23:0]   rgb_out;
  logic          hs_out, vs_out, de_out, hs_pol, vs_pol;
  logic [HW-1:0] h_total, h_active;
  logic [VW-1:0] v_total, v_active;
  logic          meas_valid;

  int tests;
  int fails;

  // Stream geometry currently generated
  int   t_htot, t_hact, t_hsw, t_vtot, t_vact, t_vsw;
  logic t_hneg, t_vneg;

  // Reference model state
  logic          prev_vb;
  int            fe_count;
  logic          exp_hs_pol, exp_vs_pol, exp_mv;
  logic [HW-1:0] exp_ht, exp_ha, cur_ht, cur_ha;
  logic [VW-1:0] exp_vt, exp_va, cur_vt, cur_va;

  hdmi_sync_normalizer #(.HCNT_W(HW), .VCNT_W(VW)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ce_pix     (ce_pix),
    .rgb_in     (rgb_in),
    .HSync      (HSync),
    .VSync      (VSync),
    .HBlank     (HBlank),
    .VBlank     (VBlank),
    .rgb_out    (rgb_out),
    .hs_out     (hs_out),
    .vs_out     (vs_out),
    .de_out     (de_out),
    .hs_pol     (hs_pol),
    .vs_pol     (vs_pol),
    .h_total    (h_total),
    .h_active   (h_active),
    .v_total    (v_total),
    .v_active   (v_active),
    .meas_valid (meas_valid)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_meas();
    chk("h_total", 32'(h_total), 32'(exp_ht));
    chk("h_active", 32'(h_active), 32'(exp_ha));
    chk("v_total", 32'(v_total), 32'(exp_vt));
    chk("v_active", 32'(v_active), 32'(exp_va));
    chk("meas_valid", 32'(meas_valid), 32'(exp_mv));
  endtask

  task automatic chk_video(input logic [23:0] e_rgb, input logic e_de, input logic e_hs, input logic e_vs);
    chk("rgb_out", 32'(rgb_out), 32'(e_rgb));
    chk("de_out", 32'(de_out), 32'(e_de));
    chk("hs_out", 32'(hs_out), 32'(e_hs));
    chk("vs_out", 32'(vs_out), 32'(e_vs));
    chk("hs_pol", 32'(hs_pol), 32'(exp_hs_pol));
    chk("vs_pol", 32'(vs_pol), 32'(exp_vs_pol));
  endtask

  task automatic model_reset();
    prev_vb    = 1'b0;
    fe_count   = 0;
    exp_hs_pol = 1'b0;
    exp_vs_pol = 1'b0;
    exp_mv     = 1'b0;
    exp_ht     = '0;
    exp_ha     = '0;
    exp_vt     = '0;
    exp_va     = '0;
  endtask

  // One ce_pix pixel followed by `gap` idle clocks during which outputs must hold.
  task automatic pix(input logic hs, input logic vs, input logic hb, input logic vb, input int gap);
    logic [23:0] d;
    logic        e_de, e_hs, e_vs, fe;
    logic [23:0] e_rgb;
    d     = 24'($urandom);
    e_de  = ~(hb | vb);
    e_rgb = e_de ? d : 24'h0;
    e_hs  = hs ^ exp_hs_pol;
    e_vs  = vs ^ exp_vs_pol;
    fe    = vb & ~prev_vb;
    rgb_in = d; HSync = hs; VSync = vs; HBlank = hb; VBlank = vb; ce_pix = 1'b1;
    @(posedge clk_sys); #1;
    ce_pix  = 1'b0;
    prev_vb = vb;
    if (fe) begin
      if (fe_count > 0) begin
        exp_hs_pol = t_hneg;
        exp_vs_pol = t_vneg;
`ifdef HDMI_SYNC_MEAS_EN
        exp_mv = (cur_ht == exp_ht) && (cur_vt == exp_vt);
        exp_ht = cur_ht;
        exp_ha = cur_ha;
        exp_vt = cur_vt;
        exp_va = cur_va;
`endif
      end
      fe_count++;
    end
    chk_video(e_rgb, e_de, e_hs, e_vs);
    chk_meas();
    for (int g = 0; g < gap; g++) begin
      @(posedge clk_sys); #1;
      chk_video(e_rgb, e_de, e_hs, e_vs);
    end
  endtask

  // Emits `nlines` lines from line 0 of the current geometry; the frame end lies at line t_vact.
  task automatic frame(input int nlines);
    cur_ht = HW'(t_htot);
    cur_ha = HW'(t_hact);
    cur_vt = VW'(t_vtot);
    cur_va = VW'(t_vact);
    for (int l = 0; l < nlines; l++) begin
      for (int p = 0; p < t_htot; p++) begin
        logic hs_act, vs_act;
        hs_act = (p > t_hact) && (p <= t_hact + t_hsw);
        vs_act = (l > t_vact) && (l <= t_vact + t_vsw);
        pix(hs_act ^ t_hneg, vs_act ^ t_vneg, p >= t_hact, l >= t_vact, int'($urandom_range(0, 3)));
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rgb"}, 32'(rgb_out), 32'h0);
    chk({tag, "_de"}, 32'(de_out), 32'h0);
    chk({tag, "_hs"}, 32'(hs_out), 32'h0);
    chk({tag, "_vs"}, 32'(vs_out), 32'h0);
    chk({tag, "_hpol"}, 32'(hs_pol), 32'h0);
    chk({tag, "_vpol"}, 32'(vs_pol), 32'h0);
    chk({tag, "_htot"}, 32'(h_total), 32'h0);
    chk({tag, "_hact"}, 32'(h_active), 32'h0);
    chk({tag, "_vtot"}, 32'(v_total), 32'h0);
    chk({tag, "_vact"}, 32'(v_active), 32'h0);
    chk({tag, "_valid"}, 32'(meas_valid), 32'h0);
  endtask

  initial begin
    tests = 0; fails = 0;
    reset_n = 1'b0; ce_pix = 1'b0; rgb_in = '0;
    HSync = 1'b0; VSync = 1'b0; HBlank = 1'b0; VBlank = 1'b0;
    cur_ht = '0; cur_ha = '0; cur_vt = '0; cur_va = '0;
    model_reset();
    repeat (3) @(posedge clk_sys);
    #1;
    chk_all_zero("reset");
    reset_n = 1'b1;

    // Session 1: random geometry and polarities, three frames to lock
    t_htot = int'($urandom_range(24, 40));
    t_hact = t_htot - int'($urandom_range(8, 12));
    t_hsw  = int'($urandom_range(2, 5));
    t_vtot = int'($urandom_range(8, 12));
    t_vact = t_vtot - int'($urandom_range(3, 5));
    t_vsw  = int'($urandom_range(1, 2));
    t_hneg = 1'($urandom);
    t_vneg = 1'($urandom);
    repeat (3) frame(t_vtot);

    // Horizontal total changes: lock drops at the next frame end and returns one frame later
    t_htot = t_htot + int'($urandom_range(2, 6));
    repeat (2) frame(t_vtot);

    // Reset asserted mid-frame clears every output without a clock edge
    frame(2);
    pix(1'b0 ^ t_hneg, 1'b0 ^ t_vneg, 1'b0, 1'b0, 0);
    reset_n = 1'b0;
    #2;
    chk_all_zero("async_rst");
    model_reset();
    repeat (2) @(posedge clk_sys);
    #1;
    chk_all_zero("rst_hold");
    reset_n = 1'b1;

    // Session 2: scaled VGA-like stream with active-low syncs
    t_htot = 40; t_hact = 32; t_hsw = 5;
    t_vtot = 13; t_vact = 10; t_vsw = 2;
    t_hneg = 1'b1; t_vneg = 1'b1;
    repeat (3) frame(t_vtot);

    // Overlong line: horizontal counters saturate; line and frame end land on one sample
    frame(t_vact - 1);
    repeat (5000) pix(1'b1, t_vneg, 1'b0, 1'b0, 0);
    cur_ht = '1;
    cur_ha = '1;
    cur_vt = VW'(t_vtot);
    cur_va = VW'(t_vact - 1);
    pix(1'b1, t_vneg, 1'b1, 1'b1, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
